// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / periodic expiry, enable, and abort.
// count and tc are registered; load_ready, busy and done decode from the state register.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_next;
    logic             r_mode;
    logic             w_mode_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             w_load_accept;
    logic             w_count_last;

    assign load_ready    = (r_state != ST_RUN);
    assign busy          = (r_state == ST_RUN);
    assign done          = (r_state == ST_DONE);
    assign count         = r_count;
    assign tc            = r_tc;

    assign w_load_accept = load_valid & load_ready;
    // count is never 0 in RUN, so "<= 1" means this enabled cycle expires the count.
    assign w_count_last  = (r_count <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_reload <= w_reload_next;
            r_mode   <= w_mode_next;
            r_tc     <= w_tc_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_reload_next = r_reload;
        w_mode_next   = r_mode;
        w_tc_next     = 1'b0;

        if (w_load_accept) begin
            w_count_next  = load_val;
            w_reload_next = load_val;
            if (load_val == '0) begin
                // A zero load expires immediately and is always one-shot.
                w_mode_next  = 1'b0;
                w_tc_next    = 1'b1;
                w_state_next = ST_DONE;
            end else begin
                w_mode_next  = auto_reload;
                w_state_next = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (abort) begin
                        w_count_next = '0;
                        w_state_next = ST_IDLE;
                    end else if (en) begin
                        if (!w_count_last) begin
                            w_count_next = r_count - WIDTH'(1);
                        end else if (r_mode) begin
                            w_count_next = r_reload;
                            w_tc_next    = 1'b1;
                        end else begin
                            w_count_next = '0;
                            w_tc_next    = 1'b1;
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed and randomized checks of down_timer against an expiry-count reference model.
module tb_down_timer;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_val = '0;
    logic             auto_reload = 1'b0;
    logic             en = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase (0 idle, 1 run, 2 done), load value n, periodic flag,
    // and k = enabled cycles elapsed in the current period. In RUN, count = n - k.
    int m_phase = 0;
    int m_n = 0;
    bit m_per = 1'b0;
    int m_k = 0;
    bit m_tc = 1'b0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH+3:0] m_expect();
        logic [WIDTH-1:0] c;
        c = (m_phase == 1) ? WIDTH'(m_n - m_k) : '0;
        return {c, m_tc, (m_phase == 1), (m_phase == 2), (m_phase != 1)};
    endfunction

    task automatic model_update();
        m_tc = 1'b0;
        if (rst) begin
            m_phase = 0; m_n = 0; m_k = 0; m_per = 1'b0;
        end else if (m_phase != 1 && load_valid) begin
            m_n = int'(load_val);
            m_k = 0;
            if (m_n == 0) begin
                m_phase = 2; m_tc = 1'b1; m_per = 1'b0;
            end else begin
                m_phase = 1; m_per = auto_reload;
            end
        end else if (m_phase == 1) begin
            if (abort) begin
                m_phase = 0; m_k = 0;
            end else if (en) begin
                m_k++;
                if (m_k == m_n) begin
                    m_tc = 1'b1;
                    m_k = 0;
                    if (!m_per) m_phase = 2;
                end
            end
        end else if (m_phase == 2 && abort) begin
            m_phase = 0;
        end
    endtask

    task automatic step(input bit r, input bit lv, input int lval, input bit ar,
                        input bit e, input bit ab);
        rst = r; load_valid = lv; load_val = WIDTH'(lval);
        auto_reload = ar; en = e; abort = ab;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), int'($urandom_range(0, MAXV)), 1'($urandom), 1'b1, 1'($urandom));
            vectors++;
            if ({count, tc, busy, done, load_ready} !== 8'b0000_0001) begin
                miscompares++;
                $display("FAIL reset: got count=%0d tc=%b busy=%b done=%b ready=%b, want 0/0/0/0/1",
                         count, tc, busy, done, load_ready);
            end
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_oneshot();
        int seq[6] = '{5, 4, 3, 2, 1, 0};
        step(1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({count, tc, busy, done, load_ready} !== m_expect()) begin
                miscompares++;
                $display("FAIL oneshot[%0d]: got %h want %h", i, {count, tc, busy, done, load_ready}, m_expect());
            end
            vectors++;
            if (count !== WIDTH'(seq[(i < 5) ? i : 5]) || tc !== (i == 5)) begin
                miscompares++;
                $display("FAIL oneshot_seq[%0d]: got count=%0d tc=%b want count=%0d tc=%b",
                         i, count, tc, seq[(i < 5) ? i : 5], (i == 5));
            end
            step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_done: got done=%b want 1", done);
        end
    endtask

    task automatic test_periodic();
        int seq[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
        int pulses = 0;
        step(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (tc === 1'b1) pulses++;
            vectors++;
            if (count !== WIDTH'(seq[i]) || busy !== 1'b1 || tc !== (i == 3 || i == 6)
                || {count, tc, busy, done, load_ready} !== m_expect()) begin
                miscompares++;
                $display("FAIL periodic[%0d]: got count=%0d tc=%b busy=%b want count=%0d tc=%b busy=1",
                         i, count, tc, busy, seq[i], (i == 3 || i == 6));
            end
            step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        end
        if (tc === 1'b1) pulses++;
        vectors++;
        if (pulses !== 3 || count !== WIDTH'(3)) begin
            miscompares++;
            $display("FAIL periodic_pulses: got %0d pulses count=%0d want 3 pulses count=3", pulses, count);
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_enable_gaps();
        int seq[7] = '{4, 3, 3, 3, 2, 1, 0};
        bit ens[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int pulses = 0;
        step(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (tc === 1'b1) pulses++;
            vectors++;
            if (count !== WIDTH'(seq[i]) || {count, tc, busy, done, load_ready} !== m_expect()) begin
                miscompares++;
                $display("FAIL enable_gaps[%0d]: got count=%0d tc=%b want count=%0d", i, count, tc, seq[i]);
            end
            if (i < 6) step(1'b0, 1'b0, 0, 1'b0, ens[i], 1'b0);
        end
        vectors++;
        if (pulses !== 1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_gaps_tc: got %0d pulses done=%b want 1 pulse done=1", pulses, done);
        end
    endtask

    task automatic test_abort();
        bit seen_tc = 1'b0;
        step(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        // A load attempt mid-run must be ignored.
        step(1'b0, 1'b1, 9, 1'b1, 1'b1, 1'b0);
        seen_tc |= tc;
        vectors++;
        if (load_ready !== 1'b0 || count !== WIDTH'(1) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_ignore_load: got ready=%b count=%0d busy=%b want 0/1/1", load_ready, count, busy);
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        seen_tc |= tc;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1 || seen_tc !== 1'b0
                || {count, tc, busy, done, load_ready} !== m_expect()) begin
                miscompares++;
                $display("FAIL abort[%0d]: got count=%0d busy=%b done=%b tc_seen=%b want 0/0/0/0",
                         i, count, busy, done, seen_tc);
            end
            step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
            seen_tc |= tc;
        end
    endtask

    task automatic test_zero_and_max();
        int pulses = 0;
        int cycles = 0;
        step(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (tc !== 1'b1 || done !== 1'b1 || count !== '0) begin
            miscompares++;
            $display("FAIL zero_load: got tc=%b done=%b count=%0d want 1/1/0", tc, done, count);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
            vectors++;
            if (tc !== 1'b0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_load_hold[%0d]: got tc=%b done=%b want 0/1", i, tc, done);
            end
        end
        step(1'b0, 1'b1, MAXV, 1'b0, 1'b1, 1'b0);
        while (tc !== 1'b1 && cycles < 40) begin
            step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
            cycles++;
            if (tc === 1'b1) pulses++;
        end
        vectors++;
        if (cycles !== MAXV || pulses !== 1 || count !== '0 || {count, tc, busy, done, load_ready} !== m_expect()) begin
            miscompares++;
            $display("FAIL max_load: got %0d cycles to tc (count=%0d) want %0d", cycles, count, MAXV);
        end
    endtask

    task automatic test_done_load_abort();
        // DONE: simultaneous load and abort -> load wins.
        step(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (count !== WIDTH'(6) || busy !== 1'b1 || {count, tc, busy, done, load_ready} !== m_expect()) begin
            miscompares++;
            $display("FAIL done_load_wins: got count=%0d busy=%b want 6/1", count, busy);
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (done !== 1'b0 || load_ready !== 1'b1 || count !== '0) begin
            miscompares++;
            $display("FAIL done_abort: got done=%b ready=%b count=%0d want 0/1/0", done, load_ready, count);
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({count, tc, busy, done, load_ready} !== 8'b0000_0001) begin
            miscompares++;
            $display("FAIL idle_abort: got %h want 01", {count, tc, busy, done, load_ready});
        end
    endtask

    task automatic test_reset_midcount();
        bit seen_tc = 1'b0;
        step(1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (count !== WIDTH'(7)) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got count=%0d want 7", count);
        end
        step(1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0);
        seen_tc |= tc;
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        seen_tc |= tc;
        vectors++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || seen_tc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got count=%0d busy=%b done=%b tc_seen=%b want 0/0/0/0",
                     count, busy, done, seen_tc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
                 1'($urandom), ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 4));
            vectors++;
            if ({count, tc, busy, done, load_ready} !== m_expect()) begin
                miscompares++;
                $display("FAIL random[%0d]: got count=%0d tc=%b busy=%b done=%b ready=%b want %h",
                         i, count, tc, busy, done, load_ready, m_expect());
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_reset();
        test_enable_gaps();
        test_abort();
        test_zero_and_max();
        test_done_load_abort();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
